// File: rtl/demux_router_pkg.sv
// Shared types and defaults for the demux_router lane demultiplexer.
// Holds the FSM encoding and the default beat/select widths.
package demux_router_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_lane.sv
// One-entry valid/ready holding register for a single output lane.
// Latency 1 cycle from load to valid; the entry holds while valid && !ready.
// A load while draining replaces the entry, so one beat per cycle is sustained.
module demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      // Payload is left in place after a drain; only valid drops.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-2**SEL_W demux with packet lane locking; optional broadcast via DEMUX_ROUTER_BCAST_EN.
// Latency: an accepted beat appears on its lane exactly 1 cycle later.
// Backpressure: in_ready drops when the target lane (all lanes for broadcast) is full and not ready.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_last,
`ifdef DEMUX_ROUTER_BCAST_EN
  input  logic                        in_bcast,
`endif
  output logic [(2**SEL_W)-1:0]       out_valid,
  input  logic [(2**SEL_W)-1:0]       out_ready,
  output logic [(2**SEL_W)*WIDTH-1:0] out_data,
  output logic [(2**SEL_W)-1:0]       out_last,
  output logic                        busy
);

  localparam int NOUT = 2 ** SEL_W;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] tgt;
  logic [NOUT-1:0]  lane_free;
  logic [NOUT-1:0]  lane_load;
  logic             bcast;
  logic             accept;

  // In PKT the locked select wins; in_sel is only meaningful on a first beat.
  assign tgt       = (state == ST_PKT) ? lock_sel : in_sel;
  assign lane_free = ~out_valid | out_ready;

`ifdef DEMUX_ROUTER_BCAST_EN
  logic lock_bcast;

  assign bcast = (state == ST_PKT) ? lock_bcast : in_bcast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_bcast <= 1'b0;
    end else if (state == ST_IDLE && accept && !in_last) begin
      lock_bcast <= in_bcast;
    end
  end
`else
  assign bcast = 1'b0;
`endif

  // No in_valid term here, so in_ready never depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = bcast ? (&lane_free) : lane_free[tgt];
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    lane_load = '0;
    for (int i = 0; i < NOUT; i++) begin
      lane_load[i] = accept && (bcast || (tgt == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_sel <= '0;
    end else if (state == ST_IDLE && accept && !in_last) begin
      lock_sel <= in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !in_last) state_nxt = ST_PKT;
      ST_PKT:  if (accept && in_last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_PKT);
  end

  for (genvar i = 0; i < NOUT; i++) begin : g_lane
    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lane_load[i]),
      .load_data(in_data),
      .load_last(in_last),
      .ready    (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (out_data[i*WIDTH +: WIDTH]),
      .last     (out_last[i])
    );
  end

endmodule

// File: tb/tb_demux_router.sv
// Directed plus random test of demux_router against a per-lane queue model.
// Broadcast steps are included when DEMUX_ROUTER_BCAST_EN is defined.
module tb_demux_router;

  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
  localparam int NOUT  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data = '0;
  logic [SEL_W-1:0]        in_sel = '0;
  logic                    in_last = 1'b0;
  logic [NOUT-1:0]         out_valid;
  logic [NOUT-1:0]         out_ready = '1;
  logic [NOUT*WIDTH-1:0]   out_data;
  logic [NOUT-1:0]         out_last;
  logic                    busy;
`ifdef DEMUX_ROUTER_BCAST_EN
  logic                    in_bcast = 1'b0;
`endif

  int npass  = 0;
  int ntotal = 0;

  // Model: beats accepted but not yet drained, per lane, as {last, data}.
  logic [WIDTH:0] q[NOUT][$];
  bit             m_pkt = 1'b0;
  int             m_lock = 0;
  bit             m_lock_bc = 1'b0;

  always #5 clk = ~clk;

  demux_router #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
`ifdef DEMUX_ROUTER_BCAST_EN
    .in_bcast (in_bcast),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_tgt();
    return m_pkt ? m_lock : int'(in_sel);
  endfunction

  function automatic bit m_bc();
`ifdef DEMUX_ROUTER_BCAST_EN
    return m_pkt ? m_lock_bc : in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    if (!rst_n) return 1'b0;
    if (m_bc()) begin
      for (int i = 0; i < NOUT; i++)
        if (q[i].size() != 0 && !out_ready[i]) return 1'b0;
      return 1'b1;
    end
    return (q[m_tgt()].size() == 0) || out_ready[m_tgt()];
  endfunction

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    bit acc;
    int t;
    bit b;
    #1;
    chk("in_ready", in_ready, m_ready());
    chk("busy", busy, m_pkt);
    for (int i = 0; i < NOUT; i++) begin
      chk($sformatf("out_valid[%0d]", i), out_valid[i], q[i].size() != 0);
      if (q[i].size() != 0)
        chk($sformatf("lane%0d_beat", i), {out_last[i], out_data[i*WIDTH +: WIDTH]}, q[i][0]);
    end
    acc = in_valid && m_ready();
    t   = m_tgt();
    b   = m_bc();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NOUT; i++) q[i].delete();
      m_pkt = 1'b0; m_lock = 0; m_lock_bc = 1'b0;
    end else begin
      for (int i = 0; i < NOUT; i++)
        if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
      if (acc) begin
        for (int i = 0; i < NOUT; i++)
          if (b || i == t) q[i].push_back({in_last, in_data});
        if (!m_pkt && !in_last) begin
          m_pkt = 1'b1; m_lock = t; m_lock_bc = b;
        end else if (m_pkt && in_last) begin
          m_pkt = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] d, input logic l);
    in_valid = 1'b1; in_sel = sel; in_data = d; in_last = l;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [NOUT-1:0] zero_v;
    zero_v = '0;
    @(negedge clk);

    // Reset for two cycles
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, zero_v);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", out_last, zero_v);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Single-beat packet to lane 2
    beat(2'd2, 8'hA5, 1'b1);
    chk("single_valid", out_valid, 4'b0100);
    chk("single_data", out_data[23:16], 8'hA5);
    chk("single_busy", busy, 1'b0);
    step();

    // Three-beat packet locked to lane 1 despite in_sel changing
    beat(2'd1, 8'h11, 1'b0);
    chk("pkt_busy_after_b0", busy, 1'b1);
    chk("pkt_lane1_b0", out_data[15:8], 8'h11);
    beat(2'd3, 8'h22, 1'b0);
    chk("pkt_lane1_b1", out_data[15:8], 8'h22);
    beat(2'd3, 8'h33, 1'b1);
    chk("pkt_busy_after_b2", busy, 1'b0);
    chk("pkt_lane1_b2", out_data[15:8], 8'h33);
    chk("pkt_lane3_idle", out_valid[3], 1'b0);
    step();

    // Backpressure on lane 0
    out_ready = 4'b1110;
    beat(2'd0, 8'h44, 1'b1);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; in_last = 1'b1;
    step();
    step();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold_data", out_data[7:0], 8'h44);
    out_ready = 4'b1111;
    step();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid[0], 1'b1);
    chk("bp_second_data", out_data[7:0], 8'h55);
    step();

    // Eight back-to-back beats into lane 3
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'(8'h80 + k); in_last = 1'b1;
      #1;
      chk("tput_in_ready", in_ready, 1'b1);
      #0;
      step();
      chk("tput_valid3", out_valid[3], 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk("tput_drained", out_valid[3], 1'b0);

    // Reset in the middle of a four-beat packet
    beat(2'd2, 8'h61, 1'b0);
    beat(2'd2, 8'h62, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", out_valid, zero_v);
    chk("midrst_busy", busy, 1'b0);
    beat(2'd0, 8'h77, 1'b1);
    chk("midrst_route", out_valid, 4'b0001);
    chk("midrst_data", out_data[7:0], 8'h77);
    step();

`ifdef DEMUX_ROUTER_BCAST_EN
    // Broadcast stalled by lane 1, then released
    out_ready = 4'b1101;
    beat(2'd1, 8'h10, 1'b1);
    in_bcast = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A; in_last = 1'b1;
    step();
    chk("bc_stall", in_ready, 1'b0);
    out_ready = 4'b1111;
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    chk("bc_all_valid", out_valid, 4'b1111);
    chk("bc_all_data", out_data, 32'h5A5A5A5A);
    step();
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = SEL_W'($urandom);
      in_data   = WIDTH'($urandom);
      in_last   = ($urandom_range(2) == 0);
      out_ready = NOUT'($urandom) | NOUT'($urandom);
      rst_n     = ($urandom_range(199) != 0);
`ifdef DEMUX_ROUTER_BCAST_EN
      in_bcast  = ($urandom_range(7) == 0);
`endif
      step();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = '1;
    step();
    step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
